// File: rtl/fifo_serial_tx_if.sv
// fifo_serial_tx_if: FIFO read-side and serial-line signals of the FIFO serial transmitter.
// master = transmitter side, slave = FIFO/line side.
interface fifo_serial_tx_if #(parameter int DATA_WIDTH = 10);
   logic                  FIFO_EMPTY;
   logic [DATA_WIDTH-1:0] FIFO_DOUT;
   logic                  FIFO_RD_EN;
   logic                  TX;
   logic                  BUSY;
   logic                  FRAME_DONE;
   modport master (input FIFO_EMPTY, FIFO_DOUT, output FIFO_RD_EN, TX, BUSY, FRAME_DONE);
   modport slave (output FIFO_EMPTY, FIFO_DOUT, input FIFO_RD_EN, TX, BUSY, FRAME_DONE);
endinterface

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops one FIFO word per frame and sends start, data LSB first, [parity], stop.
// Define SER_TX_PARITY_EN to add an even-parity bit after the data bits.
module fifo_serial_tx #(
   parameter int DATA_WIDTH   = 10,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1
) (
   input logic CLK,
   input logic RST,
   fifo_serial_tx_if.master bus
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] READ   = 3'd1;
   localparam logic [2:0] LOAD   = 3'd2;
   localparam logic [2:0] START  = 3'd3;
   localparam logic [2:0] DATA   = 3'd4;
`ifdef SER_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd5;
`endif
   localparam logic [2:0] STOP   = 3'd6;

   logic [2:0]            r_state, w_state_n;
   logic [CW-1:0]         r_cnt, w_cnt_n;
   logic [BW-1:0]         r_bit, w_bit_n;
   logic [DATA_WIDTH-1:0] r_shreg, w_shreg_n;
   logic                  r_tx, r_rd_en, r_busy, r_done, w_tx_n;
   logic                  w_last, w_timed;
`ifdef SER_TX_PARITY_EN
   logic                  r_par;
`endif

   assign w_last  = r_cnt == CNT_LAST;
   assign w_timed = r_state >= START;

   // Outputs are registered from the next state so they change together with it.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = (w_timed && !w_last) ? r_cnt + CW'(1) : '0;
      w_bit_n   = r_bit;
      w_shreg_n = r_shreg;
      case (r_state)
         IDLE:  w_state_n = bus.FIFO_EMPTY ? IDLE : READ;
         READ:  w_state_n = LOAD;
         LOAD: begin
            w_state_n = START;
            w_shreg_n = bus.FIFO_DOUT;
            w_bit_n   = '0;
         end
         START: w_state_n = w_last ? DATA : START;
         DATA: if (w_last) begin
            w_shreg_n = r_shreg >> 1;
            w_bit_n   = (r_bit == BIT_LAST) ? '0 : r_bit + BW'(1);
`ifdef SER_TX_PARITY_EN
            w_state_n = (r_bit == BIT_LAST) ? PARITY : DATA;
`else
            w_state_n = (r_bit == BIT_LAST) ? STOP : DATA;
`endif
         end
`ifdef SER_TX_PARITY_EN
         PARITY: w_state_n = w_last ? STOP : PARITY;
`endif
         STOP: if (w_last) begin
            w_bit_n   = (r_bit == STOP_LAST) ? '0 : r_bit + BW'(1);
            w_state_n = (r_bit == STOP_LAST) ? IDLE : STOP;
         end
         default: w_state_n = IDLE;
      endcase
      w_tx_n = (w_state_n == START) ? 1'b0 : (w_state_n == DATA) ? w_shreg_n[0] : 1'b1;
`ifdef SER_TX_PARITY_EN
      if (w_state_n == PARITY) w_tx_n = r_par;
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shreg <= '0;
         r_tx    <= 1'b1;
         r_rd_en <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_bit   <= w_bit_n;
         r_shreg <= w_shreg_n;
         r_tx    <= w_tx_n;
         r_rd_en <= w_state_n == READ;
         r_busy  <= w_state_n != IDLE;
         r_done  <= w_state_n == STOP && w_cnt_n == CNT_LAST && w_bit_n == STOP_LAST;
      end
   end

`ifdef SER_TX_PARITY_EN
   always_ff @(posedge CLK) begin
      if (RST) r_par <= 1'b0;
      else if (r_state == LOAD) r_par <= ^bus.FIFO_DOUT;
   end
`endif

   assign bus.FIFO_RD_EN = r_rd_en;
   assign bus.TX         = r_tx;
   assign bus.BUSY       = r_busy;
   assign bus.FRAME_DONE = r_done;
endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: table vectors, corner sequences and random traffic for fifo_serial_tx,
// checked every cycle against a frame-level reference model.
module tb_fifo_serial_tx;
   localparam int DW  = 10;
   localparam int CPB = 4;
   localparam int SB  = 1;
`ifdef SER_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int L = (1 + DW + P + SB) * CPB;

   typedef struct {
      logic [DW-1:0] word;
      logic [0:10]   head;
   } vec_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   fifo_serial_tx_if #(.DATA_WIDTH(DW)) bus();
   fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   int n_pass = 0, n_tot = 0, cyc = 0;
   logic s_rst, s_empty;
   logic [DW-1:0] q[$], exp_q[$];
   int rd_log[$];
   bit mon_en = 0, act = 0, busy_prev = 0;
   int st = 0;
   logic [DW-1:0] w = '0;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_tot++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, a, e);
   endtask

   function automatic logic line_bit(input logic [DW-1:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= DW) return d[k-1];
      if (P == 1 && k == DW + 1) return ^d;
      return 1'b1;
   endfunction

   task automatic push(input logic [DW-1:0] d);
      q.push_back(d);
      exp_q.push_back(d);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge CLK);
   endtask

   task automatic wait_rd(output int r);
      r = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         if (bus.FIFO_RD_EN === 1'b1) begin
            r = cyc;
            break;
         end
      end
      chk("rd_timeout", r >= 0, 1);
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      do begin
         @(negedge CLK);
         k++;
      end while ((q.size() != 0 || bus.BUSY !== 1'b0) && k < lim);
      repeat (3) @(negedge CLK);
      chk("idle_timeout", k < lim, 1);
   endtask

   always @(posedge CLK) begin
      cyc++;
      s_rst   = RST;
      s_empty = bus.FIFO_EMPTY;
   end

   // Reference: a read happens one cycle after the line is free and the FIFO is non-empty;
   // the frame starts two cycles later and is L cycles long.
   always @(negedge CLK) begin
      logic rd_e, busy_e, tx_e, done_e;
      if (mon_en) begin
         rd_e = 1'b0;
         if (s_rst) act = 0;
         else if (!busy_prev && !s_empty) begin
            rd_e = 1'b1;
            act  = 1;
            st   = cyc + 2;
            w    = exp_q.size() != 0 ? exp_q.pop_front() : '0;
         end
         busy_e = act;
         done_e = act && cyc == st + L - 1;
         tx_e   = (act && cyc >= st) ? line_bit(w, (cyc - st) / CPB) : 1'b1;
         chk($sformatf("cycle%0d rd/busy/tx/done", cyc),
             {bus.FIFO_RD_EN, bus.BUSY, bus.TX, bus.FRAME_DONE}, {rd_e, busy_e, tx_e, done_e});
         if (done_e) act = 0;
         busy_prev = busy_e;
         if (bus.FIFO_RD_EN === 1'b1) rd_log.push_back(cyc);
      end
      if (bus.FIFO_RD_EN === 1'b1) begin
         if (q.size() == 0) chk("read_from_empty", 1, 0);
         else bus.FIFO_DOUT = q.pop_front();
      end
      bus.FIFO_EMPTY = q.size() == 0;
   end

   initial begin
      vec_t tbl[6];
      int r, n0, bad;
      bit got;
      tbl[0] = '{10'h2A5, 11'b0_1010010101};
      tbl[1] = '{10'h000, 11'b0_0000000000};
      tbl[2] = '{10'h3FF, 11'b0_1111111111};
      tbl[3] = '{10'h001, 11'b0_1000000000};
      tbl[4] = '{10'h200, 11'b0_0000000001};
      tbl[5] = '{10'h155, 11'b0_1010101010};
      bus.FIFO_EMPTY = 1'b1;
      bus.FIFO_DOUT  = '0;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_tx", bus.TX, 1);
      chk("reset_rd_en", bus.FIFO_RD_EN, 0);
      chk("reset_busy", bus.BUSY, 0);
      chk("reset_frame_done", bus.FRAME_DONE, 0);
      RST = 1'b0;
      mon_en = 1;

      for (int i = 0; i < 6; i++) begin
         @(posedge CLK);
         #1;
         push(tbl[i].word);
         wait_rd(r);
         if (r >= 0) begin
            for (int j = 0; j < 11; j++) begin
               wait_cyc(r + 2 + j * CPB + 1);
               chk($sformatf("tbl%0d_bit%0d", i, j), bus.TX, tbl[i].head[j]);
            end
`ifdef SER_TX_PARITY_EN
            wait_cyc(r + 2 + 11 * CPB + 1);
            chk($sformatf("tbl%0d_parity", i), bus.TX, ^tbl[i].word);
`endif
            wait_cyc(r + L);
            chk($sformatf("tbl%0d_done_early", i), bus.FRAME_DONE, 0);
            wait_cyc(r + L + 1);
            chk($sformatf("tbl%0d_done", i), {bus.FRAME_DONE, bus.TX, bus.BUSY}, 3'b111);
            wait_cyc(r + L + 2);
            chk($sformatf("tbl%0d_after", i), {bus.FRAME_DONE, bus.BUSY}, 2'b00);
         end
      end

      n0 = rd_log.size();
      @(posedge CLK);
      #1;
      for (int i = 0; i < 3; i++) push(DW'($urandom_range(0, 1023)));
      wait_idle(400);
      chk("three_reads", rd_log.size() - n0, 3);
      for (int i = n0 + 1; i < n0 + 3 && i < rd_log.size(); i++)
         chk($sformatf("read_gap%0d_ge51", i - n0), rd_log[i] - rd_log[i-1] >= 51, 1);

      n0 = rd_log.size();
      bad = 0;
      repeat (100) begin
         @(negedge CLK);
         if (bus.TX !== 1'b1 || bus.BUSY !== 1'b0 || bus.FIFO_RD_EN !== 1'b0) bad++;
      end
      chk("empty_idle_glitches", bad, 0);
      chk("empty_idle_reads", rd_log.size() - n0, 0);

      @(posedge CLK);
      #1;
      push(10'h2A5);
      push(10'h0F3);
      wait_rd(r);
      if (r >= 0) begin
         wait_cyc(r + 2 + CPB + 4 * CPB + 1);
         @(posedge CLK);
         #1;
         RST = 1'b1;
         @(posedge CLK);
         #1;
         chk("midrst_out", {bus.TX, bus.BUSY, bus.FRAME_DONE}, 3'b100);
         RST = 1'b0;
         got = 0;
         repeat (2) begin
            @(negedge CLK);
            if (bus.FIFO_RD_EN === 1'b1) got = 1;
         end
         chk("midrst_reread", got, 1);
      end
      wait_idle(300);

      for (int k = 0; k < 600; k++) begin
         @(posedge CLK);
         #1;
         if ($urandom_range(0, 11) == 0) push(DW'($urandom_range(0, 1023)));
         RST = $urandom_range(0, 299) == 0;
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      wait_idle(3000);
      chk("fifo_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
